// File: rtl/alarm_pkg.sv
// Shared definitions for the RTC alarm scheduler: FSM state encoding,
// slot register addresses and compare-field geometry.
package alarm_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RINGING = 2'd1,
      SNOOZED = 2'd2
   } state_t;

   localparam logic [1:0] ADDR_MIN  = 2'd0;
   localparam logic [1:0] ADDR_HOUR = 2'd1;
   localparam logic [1:0] ADDR_DAY  = 2'd2;
   localparam logic [1:0] ADDR_WDAY = 2'd3;

   // bit 7 of every slot register enables that field's compare
   localparam int EN_BIT = 7;

   localparam int MIN_W  = 7;
   localparam int HOUR_W = 6;
   localparam int DAY_W  = 6;
   localparam int WDAY_W = 3;

endpackage

// File: rtl/alarm_match.sv
// Combinational match function for one alarm slot.
// Ports:
//   slot_min/hour/day/wday : programmed slot registers (bit7 = field enable)
//   real_min/hour/day/weekday : current time from the timekeeping counters
//   match : slot is armed (min enabled) and every enabled field agrees
module alarm_match
   import alarm_pkg::*;
(
   input  logic [7:0] slot_min,
   input  logic [7:0] slot_hour,
   input  logic [7:0] slot_day,
   input  logic [7:0] slot_wday,
   input  logic [7:0] real_min,
   input  logic [7:0] real_hour,
   input  logic [7:0] real_day,
   input  logic [3:0] real_weekday,
   output logic       match
);

   logic min_ok, hour_ok, day_ok, wday_ok, date_ok;

   always_comb begin
      min_ok  = slot_min[MIN_W-1:0] == real_min[MIN_W-1:0];
      hour_ok = !slot_hour[EN_BIT] || (slot_hour[HOUR_W-1:0] == real_hour[HOUR_W-1:0]);
      day_ok  = slot_day[DAY_W-1:0] == real_day[DAY_W-1:0];
      wday_ok = slot_wday[WDAY_W-1:0] == real_weekday[WDAY_W-1:0];
      // with both date fields enabled, either one satisfies the alarm
      case ({slot_day[EN_BIT], slot_wday[EN_BIT]})
         2'b11:   date_ok = day_ok || wday_ok;
         2'b10:   date_ok = day_ok;
         2'b01:   date_ok = wday_ok;
         default: date_ok = 1'b1;
      endcase
      // the minute enable is the slot arm bit; nothing matches without it
      match = slot_min[EN_BIT] && min_ok && hour_ok && date_ok;
   end

endmodule

// File: rtl/alarm_scheduler.sv
// Multi-slot RTC alarm controller. Slots are compared against the running
// time on each min_tick; matching slots latch a pending flag, the lowest
// pending slot rings, and ack / snooze / auto-off retire it.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   cfg_*           : host slot register access (read data one cycle late)
//   real_*, min_tick: current time and the new-minute strobe
//   intr_ack, snooze: user stop / snooze pulses
//   irq             : high while ringing
//   ring_id         : slot ringing or snoozed
//   alarm_flag      : per-slot pending status
module alarm_scheduler
   import alarm_pkg::*;
#(
   parameter int NUM_ALARMS   = 2,
   parameter int SNOOZE_MIN   = 5,
   parameter int AUTO_OFF_MIN = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_we,
   input  logic                  cfg_re,
   input  logic [1:0]            cfg_sel,
   input  logic [1:0]            cfg_addr,
   input  logic [7:0]            cfg_wdata,
   output logic [7:0]            cfg_rdata,
   input  logic [7:0]            real_min,
   input  logic [7:0]            real_hour,
   input  logic [7:0]            real_day,
   input  logic [3:0]            real_weekday,
   input  logic                  min_tick,
   input  logic                  intr_ack,
   input  logic                  snooze,
   output logic                  irq,
   output logic [1:0]            ring_id,
   output logic [NUM_ALARMS-1:0] alarm_flag
);

   logic [7:0] slot_min  [NUM_ALARMS];
   logic [7:0] slot_hour [NUM_ALARMS];
   logic [7:0] slot_day  [NUM_ALARMS];
   logic [7:0] slot_wday [NUM_ALARMS];

   state_t                  state, state_n;
   logic [1:0]              ring_n, win_id;
   logic [5:0]              snz_cnt, snz_n, auto_cnt, auto_n;
   logic [NUM_ALARMS-1:0]   match, ring_oh, clr, flag_n;
   logic                    win_any;
   logic [7:0]              rd_data;

   for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_slot
      alarm_match u_match (
         .slot_min     (slot_min[g]),
         .slot_hour    (slot_hour[g]),
         .slot_day     (slot_day[g]),
         .slot_wday    (slot_wday[g]),
         .real_min     (real_min),
         .real_hour    (real_hour),
         .real_day     (real_day),
         .real_weekday (real_weekday),
         .match        (match[g])
      );
   end

   // lowest-index pending slot wins; selectors beyond NUM_ALARMS read as 0
   always_comb begin
      win_any = |alarm_flag;
      win_id  = 2'd0;
      rd_data = 8'd0;
      for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
         if (alarm_flag[i]) win_id = 2'(i);
      end
      for (int i = 0; i < NUM_ALARMS; i++) begin
         ring_oh[i] = (ring_id == 2'(i));
         if (cfg_sel == 2'(i)) begin
            case (cfg_addr)
               ADDR_MIN:  rd_data = slot_min[i];
               ADDR_HOUR: rd_data = slot_hour[i];
               ADDR_DAY:  rd_data = slot_day[i];
               default:   rd_data = slot_wday[i];
            endcase
         end
      end
   end

   always_comb begin
      state_n = state;
      ring_n  = ring_id;
      snz_n   = snz_cnt;
      auto_n  = auto_cnt;
      clr     = '0;
      case (state)
         IDLE: begin
            if (win_any) begin
               state_n = RINGING;
               ring_n  = win_id;
               auto_n  = 6'd0;
            end
         end
         RINGING: begin
            if (intr_ack) begin
               clr     = ring_oh;
               state_n = IDLE;
            end else if (snooze) begin
               state_n = SNOOZED;
               snz_n   = 6'(SNOOZE_MIN);
            end else if (min_tick) begin
               if (int'(auto_cnt) + 1 >= AUTO_OFF_MIN) begin
                  clr     = ring_oh;
                  state_n = IDLE;
               end else if (auto_cnt != 6'h3f) begin
                  auto_n = auto_cnt + 6'd1;
               end
            end
         end
         SNOOZED: begin
            if (intr_ack) begin
               clr     = ring_oh;
               state_n = IDLE;
            end else if (min_tick) begin
               if (snz_cnt <= 6'd1) begin
                  state_n = RINGING;
                  snz_n   = 6'd0;
                  auto_n  = 6'd0;
               end else begin
                  snz_n = snz_cnt - 6'd1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
      // reprogramming the active slot's minute retires that alarm outright
      if (state != IDLE && cfg_we && cfg_addr == ADDR_MIN && cfg_sel == ring_id) begin
         clr     = ring_oh;
         state_n = IDLE;
      end
      // a same-cycle re-match of a cleared slot keeps it pending
      flag_n = (alarm_flag & ~clr) | (match & {NUM_ALARMS{min_tick}});
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         ring_id    <= 2'd0;
         snz_cnt    <= 6'd0;
         auto_cnt   <= 6'd0;
         alarm_flag <= '0;
         cfg_rdata  <= 8'd0;
         for (int i = 0; i < NUM_ALARMS; i++) begin
            slot_min[i]  <= 8'd0;
            slot_hour[i] <= 8'd0;
            slot_day[i]  <= 8'd0;
            slot_wday[i] <= 8'd0;
         end
      end else begin
         state      <= state_n;
         ring_id    <= ring_n;
         snz_cnt    <= snz_n;
         auto_cnt   <= auto_n;
         alarm_flag <= flag_n;
         if (cfg_re) cfg_rdata <= rd_data;
         for (int i = 0; i < NUM_ALARMS; i++) begin
            if (cfg_we && cfg_sel == 2'(i)) begin
               case (cfg_addr)
                  ADDR_MIN:  slot_min[i]  <= cfg_wdata;
                  ADDR_HOUR: slot_hour[i] <= cfg_wdata;
                  ADDR_DAY:  slot_day[i]  <= cfg_wdata;
                  default:   slot_wday[i] <= cfg_wdata;
               endcase
            end
         end
      end
   end

   assign irq = (state == RINGING);

endmodule
